renode_apb3_requester: RTL

- APB3 requester (manager) that drives an APB3 completer from a simple valid/ready command channel and returns results on a valid/ready response channel.
- Sits between Renode-side bus logic (or a local bus master) and any APB3 completer, including the team's APB3 completer in loopback benches.
- One transfer outstanding at a time; strict APB3 SETUP/ACCESS sequencing with wait-state support.

---
 rtl/renode_apb3_requester_pkg.sv | 28 ++
 rtl/renode_apb3_requester_if.sv | 47 ++++
 rtl/renode_apb3_requester.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/renode_apb3_requester_pkg.sv
// Shared types and constants for the APB3 requester.
// Struct fields are sized for the widest legal configuration (32-bit address
// and data); the requester truncates them to its configured widths.
package renode_apb3_pkg;

    localparam int DefaultTimeoutCycles = 256;
    localparam int MaxAddressWidth      = 32;
    localparam int MaxDataWidth         = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [MaxAddressWidth-1:0] addr;
        logic [MaxDataWidth-1:0]    wdata;
    } apb3_cmd_t;

    typedef struct packed {
        logic [MaxDataWidth-1:0] rdata;
        logic                    slverr;
        logic                    timeout;
    } apb3_rsp_t;

endpackage

// File: rtl/renode_apb3_requester_if.sv
// Bundle of the command, response and APB3 signals of the requester.
// master: the requester's view (drives cmd_ready, rsp_*, APB outputs).
// slave : the environment's view (command source, response sink, completer).
interface renode_apb3_requester_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [AddressWidth-1:0] cmd_addr;
    logic [DataWidth-1:0]    cmd_wdata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_slverr;
    logic                    rsp_timeout;

    logic [AddressWidth-1:0] paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic                    pready;
    logic [DataWidth-1:0]    prdata;
    logic                    pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/renode_apb3_requester.sv
// APB3 requester: turns one valid/ready command into one APB3 SETUP/ACCESS
// transfer and returns the result on a valid/ready response channel.
// Optional ACCESS-phase watchdog: define RENODE_APB3_REQUESTER_TIMEOUT_EN.
module renode_apb3_requester
    import renode_apb3_pkg::*;
#(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input logic                       clk,
    input logic                       rst,
    renode_apb3_requester_if.master   bus
);

    state_t    state_q, state_d;
    apb3_cmd_t cmd_q, cmd_d;
    apb3_rsp_t rsp_q, rsp_d;
    logic      psel_q, psel_d;
    logic      penable_q, penable_d;
    logic      rsp_valid_q, rsp_valid_d;

    logic      cmd_ready_s;
    logic      cmd_hs_s;
    logic      done_s;
    logic      abort_s;
    logic      capture_s;
    logic      unused_s;

    // A pending response blocks new commands unless it drains this cycle.
    assign cmd_ready_s = (state_q == IDLE) && !rst && (!rsp_valid_q || bus.rsp_ready);
    assign cmd_hs_s    = bus.cmd_valid && cmd_ready_s;
    assign done_s      = (state_q == ACCESS) && bus.pready;
    assign capture_s   = done_s || abort_s;

`ifdef RENODE_APB3_REQUESTER_TIMEOUT_EN
    localparam int CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Expiry only while the completer still stalls; pready on the same edge wins.
    assign abort_s = (state_q == ACCESS) && !bus.pready && (cnt_q == CntLast);

    // Watchdog next value: cleared in SETUP, counts ACCESS wait cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = {CntWidth{1'b0}};
        end else if ((state_q == ACCESS) && !bus.pready) begin
            cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CntWidth{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.rsp_timeout = rsp_q.timeout;
`else
    assign abort_s         = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs_s) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (capture_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered APB outputs, command latch and response.
    always_comb begin
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;

        if (cmd_hs_s) begin
            cmd_d.write = bus.cmd_write;
            cmd_d.addr  = MaxAddressWidth'(bus.cmd_addr);
            cmd_d.wdata = MaxDataWidth'(bus.cmd_wdata);
        end else begin
            cmd_d = cmd_q;
        end

        if (capture_s) begin
            rsp_d.rdata   = (done_s && !cmd_q.write) ? MaxDataWidth'(bus.prdata)
                                                     : {MaxDataWidth{1'b0}};
            rsp_d.slverr  = done_s ? bus.pslverr : 1'b1;
            rsp_d.timeout = !done_s;
            rsp_valid_d   = 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_d       = rsp_q;
            rsp_valid_d = 1'b0;
        end else begin
            rsp_d       = rsp_q;
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Output, command and response registers; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_s;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = cmd_q.write;
    assign bus.paddr      = cmd_q.addr[AddressWidth-1:0];
    assign bus.pwdata     = cmd_q.wdata[DataWidth-1:0];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_q.rdata[DataWidth-1:0];
    assign bus.rsp_slverr = rsp_q.slverr;

    // Struct bits above the configured widths are intentionally dropped.
    assign unused_s = ^{cmd_q, rsp_q, (TimeoutCycles >= 2)};

endmodule
